dma_copy_engine: RTL

- Bus initiator for the data memory. On command, it copies a block of bytes from a source region to a destination region through the memory's address, read-enable, write-enable and data interface.
- Sits beside the CPU on the data-memory bus. It is used for program-time block moves and buffer copies.
- It never touches the I/O port addresses 0x3FE and 0x3FF. If a request would touch them, the engine rejects the whole request before any access.

---
 rtl/dma_copy_engine_if.sv | 40 ++++
 rtl/dma_copy_engine.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dma_copy_engine_if.sv
// Bus bundle for dma_copy_engine: command inputs, status outputs and the
// data-memory initiator interface. The master modport is the engine's view;
// the slave modport is the view of whoever issues commands and models memory.
//
// Handshake: in_start is a single-cycle command strobe that is accepted only
// while out_busy is low (engine in IDLE); out_busy low is the engine's ready.
// A strobe seen while out_busy is high is dropped, never queued. Completion is
// signalled by a one-cycle out_done pulse, with out_error valid from then until
// the next accepted command.
interface dma_copy_engine_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              in_start;
  logic [ADDR_W-1:0] in_src_addr;
  logic [ADDR_W-1:0] in_dst_addr;
  logic [ADDR_W-1:0] in_len;
  logic              out_busy;
  logic              out_done;
  logic              out_error;
  logic [ADDR_W-1:0] out_mem_addr;
  logic              out_mem_read_en;
  logic              out_mem_write_en;
  logic [DATA_W-1:0] out_mem_data;
  logic [DATA_W-1:0] in_mem_data;
  // Engine state for observation: 0=IDLE 1=READ 2=WRITE 3=DONE
  logic [1:0]        dbg_state;

  modport master (
    input  in_start, in_src_addr, in_dst_addr, in_len, in_mem_data,
    output out_busy, out_done, out_error, out_mem_addr, out_mem_read_en,
           out_mem_write_en, out_mem_data, dbg_state
  );

  modport slave (
    output in_start, in_src_addr, in_dst_addr, in_len, in_mem_data,
    input  out_busy, out_done, out_error, out_mem_addr, out_mem_read_en,
           out_mem_write_en, out_mem_data, dbg_state
  );
endinterface

// File: rtl/dma_copy_engine.sv
// Data-memory block copy engine. Copies in_len bytes from in_src_addr to
// in_dst_addr in ascending order, one read/write pair per byte. Commands whose
// source or destination range would reach the reserved I/O ports are rejected
// before any memory access. All bus outputs are decoded from registered state,
// so reset removes both enables asynchronously.
module dma_copy_engine #(
  parameter int                ADDR_W  = 10,
  parameter int                DATA_W  = 8,
  parameter logic [ADDR_W-1:0] IO_BASE = 10'h3FE
) (
  input  logic                clk,
  input  logic                in_rst_n,
  dma_copy_engine_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One bit wider than an address so src+len cannot overflow in the check
  localparam logic [ADDR_W:0]   LIMIT = {1'b0, IO_BASE};
  localparam logic [ADDR_W-1:0] ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_inc;
  logic [DATA_W-1:0] hold_q;
  logic              error_q;
  logic              range_bad;
  logic              last_byte;
  logic              accept;
  logic [ADDR_W:0]   src_end;
  logic [ADDR_W:0]   dst_end;

  assign src_end   = {1'b0, bus.in_src_addr} + {1'b0, bus.in_len};
  assign dst_end   = {1'b0, bus.in_dst_addr} + {1'b0, bus.in_len};
  assign range_bad = (src_end > LIMIT) || (dst_end > LIMIT);
  assign accept    = (state_q == IDLE) && bus.in_start;
  assign idx_inc   = idx_q + ONE;
  assign last_byte = (idx_inc == len_q);

  // State register, cleared asynchronously so enables drop at once on reset
  always_ff @(posedge clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.in_start) begin
          if (range_bad || (bus.in_len == '0)) begin
            state_d = DONE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ:    state_d = WRITE;
      WRITE:   state_d = last_byte ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, byte index, holding register and sticky error flag
  always_ff @(posedge clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      error_q <= 1'b0;
    end else begin
      if (accept) begin
        src_q   <= bus.in_src_addr;
        dst_q   <= bus.in_dst_addr;
        len_q   <= bus.in_len;
        idx_q   <= '0;
        error_q <= range_bad;
      end
      if (state_q == READ) begin
        hold_q <= bus.in_mem_data;
      end
      if (state_q == WRITE) begin
        idx_q <= idx_inc;
      end
    end
  end

  // Bus and status outputs decoded purely from registered state
  always_comb begin
    bus.out_busy         = 1'b0;
    bus.out_done         = 1'b0;
    bus.out_mem_addr     = '0;
    bus.out_mem_read_en  = 1'b0;
    bus.out_mem_write_en = 1'b0;
    bus.out_mem_data     = '0;
    case (state_q)
      READ: begin
        bus.out_busy        = 1'b1;
        bus.out_mem_addr    = src_q + idx_q;
        bus.out_mem_read_en = 1'b1;
      end
      WRITE: begin
        bus.out_busy         = 1'b1;
        bus.out_mem_addr     = dst_q + idx_q;
        bus.out_mem_write_en = 1'b1;
        bus.out_mem_data     = hold_q;
      end
      DONE: begin
        bus.out_busy = 1'b1;
        bus.out_done = 1'b1;
      end
      default: begin
        bus.out_busy = 1'b0;
      end
    endcase
  end

  assign bus.out_error = error_q;
  assign bus.dbg_state = state_q;

endmodule
